spi_flash_slave: RTL and testbench

SPI_FLASH_SLAVE -- requirements
Module: spi_flash_slave

---
 rtl/spi_flash_pkg.sv | 41 ++++
 rtl/spi_slave_sync.sv | 41 ++++
 rtl/spi_flash_slave.sv | 240 ++++++++++++++++++++++++
 tb/tb_spi_flash_slave.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_pkg
// Brief    : Shared opcodes, FSM state encoding and helpers for the SPI
//            flash slave.
// Revision : 1.0 - initial release
// ============================================================================
package spi_flash_pkg;

  // Command opcodes recognised in the first byte of a frame
  localparam logic [7:0] c_cmd_rdid = 8'h9F;  // read JEDEC ID
  localparam logic [7:0] c_cmd_rdsr = 8'h05;  // read status register
  localparam logic [7:0] c_cmd_read = 8'h03;  // read data
  localparam logic [7:0] c_cmd_pp   = 8'h02;  // page program
  localparam logic [7:0] c_cmd_wren = 8'h06;  // write enable
  localparam logic [7:0] c_cmd_wrdi = 8'h04;  // write disable

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_ADDR     = 3'd2,
    ST_RD_DATA  = 3'd3,
    ST_WR_DATA  = 3'd4,
    ST_ID_OUT   = 3'd5,
    ST_STAT_OUT = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  // Select one byte of the 24-bit JEDEC ID, byte 0 being the MSB
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    logic [7:0] w_b;
    case (idx)
      2'd0:    w_b = id[23:16];
      2'd1:    w_b = id[15:8];
      default: w_b = id[7:0];
    endcase
    return w_b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_sync
// Brief    : Two-flop synchronizer for one asynchronous input plus rise/fall
//            detection on the synchronized value.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability chain plus one history flop for edge detection
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign sync_out = r_sync;
  assign rise     = r_sync & ~r_prev;
  assign fall     = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_flash_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_slave
// Brief    : SPI mode-0 serial-flash slave front end. Decodes RDID, RDSR,
//            READ, PP, WREN and WRDI and bridges them onto a simple
//            byte-wide memory port.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_slave
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] ID      = 24'hEF4018,
  parameter int          DIV_MIN = 8
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        spi_csn,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  output logic        wel
);

  // Synchronizer latency plus the prefetch path needs several clocks per
  // sck half period; faster ratios cannot be supported.
  if (DIV_MIN < 6) begin : g_div_min_check
    $error("spi_flash_slave: DIV_MIN must be at least 6");
  end

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic w_csn_s, w_csn_rise, w_csn_fall;
  logic w_unused_sck_s, w_sck_rise, w_sck_fall;
  logic w_mosi_s, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_slave_sync #(.RST_VAL(1'b1)) u_sync_csn (
    .clock(clock), .rst_n(rst_n), .async_in(spi_csn),
    .sync_out(w_csn_s), .rise(w_csn_rise), .fall(w_csn_fall)
  );

  spi_slave_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clock(clock), .rst_n(rst_n), .async_in(spi_sck),
    .sync_out(w_unused_sck_s), .rise(w_sck_rise), .fall(w_sck_fall)
  );

  spi_slave_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .rst_n(rst_n), .async_in(spi_mosi),
    .sync_out(w_mosi_s), .rise(w_unused_mosi_rise), .fall(w_unused_mosi_fall)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_cmd_byte;
  logic        r_cmd_done;       // first 8 bits of the frame received
  logic        r_over;           // frame ran past its first byte
  logic        r_is_prog;
  logic        r_prog_addr_done;
  logic [1:0]  r_addr_cnt;
  logic [23:0] r_addr;
  logic [1:0]  r_id_idx;
  logic [7:0]  r_out_sr;
  logic        r_rd_d;
  logic [7:0]  r_rdbuf;
  logic [1:0]  r_settle;
  logic        r_armed;          // a clean csn high has been seen since reset

  logic [7:0]  w_byte;
  logic        w_byte_done;
  logic [23:0] w_addr_full;
  logic        w_out_state;
  logic [7:0]  w_next_byte;

  assign w_byte      = {r_shift[6:0], w_mosi_s};
  assign w_byte_done = (r_bit_cnt == 3'd7);
  assign w_addr_full = {r_addr[15:0], w_byte};
  assign w_out_state = (r_state == ST_ID_OUT) || (r_state == ST_STAT_OUT) ||
                       (r_state == ST_RD_DATA);

  // Byte presented at the start of each outgoing byte
  always_comb begin
    w_next_byte = 8'h00;
    case (r_state)
      ST_ID_OUT:   w_next_byte = id_byte(ID, r_id_idx);
      ST_STAT_OUT: w_next_byte = {6'b0, wel, 1'b0};
      ST_RD_DATA:  w_next_byte = r_rdbuf;
      default:     w_next_byte = 8'h00;
    endcase
  end

  // Frame FSM, serial shifting, memory strobes and write-enable latch
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_shift          <= 8'h00;
      r_bit_cnt        <= 3'd0;
      r_cmd_byte       <= 8'h00;
      r_cmd_done       <= 1'b0;
      r_over           <= 1'b0;
      r_is_prog        <= 1'b0;
      r_prog_addr_done <= 1'b0;
      r_addr_cnt       <= 2'd0;
      r_addr           <= 24'h0;
      r_id_idx         <= 2'd0;
      r_out_sr         <= 8'h00;
      r_rd_d           <= 1'b0;
      r_rdbuf          <= 8'h00;
      r_settle         <= 2'd0;
      r_armed          <= 1'b0;
      spi_miso         <= 1'b0;
      spi_miso_oe      <= 1'b0;
      mem_addr         <= 24'h0;
      mem_rd           <= 1'b0;
      mem_wr           <= 1'b0;
      mem_wdata        <= 8'h00;
      wel              <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;

      // Wait for the synchronizer to flush before trusting csn, so a frame
      // already in progress at reset release is ignored until csn goes high.
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      if (r_settle == 2'd3 && w_csn_s) r_armed <= 1'b1;

      // Read data arrives one clock after the strobe
      r_rd_d <= mem_rd;
      if (r_rd_d) r_rdbuf <= mem_rdata;

      if (r_state != ST_IDLE && w_csn_rise) begin
        // End of frame has priority over any coincident sck edge
        if (r_cmd_done && !r_over && r_cmd_byte == c_cmd_wren) wel <= 1'b1;
        if (r_cmd_done && !r_over && r_cmd_byte == c_cmd_wrdi) wel <= 1'b0;
        if (r_prog_addr_done) wel <= 1'b0;
        r_state     <= ST_IDLE;
        spi_miso_oe <= 1'b0;
        spi_miso    <= 1'b0;
      end else if (r_state == ST_IDLE) begin
        if (w_csn_fall && r_armed) begin
          r_state          <= ST_CMD;
          r_bit_cnt        <= 3'd0;
          r_cmd_done       <= 1'b0;
          r_over           <= 1'b0;
          r_is_prog        <= 1'b0;
          r_prog_addr_done <= 1'b0;
          r_addr_cnt       <= 2'd0;
        end
      end else begin
        if (w_sck_rise) begin
          r_shift   <= w_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_cmd_done) r_over <= 1'b1;
          if (w_byte_done) begin
            case (r_state)
              ST_CMD: begin
                r_cmd_byte <= w_byte;
                r_cmd_done <= 1'b1;
                case (w_byte)
                  c_cmd_rdid: begin
                    r_state     <= ST_ID_OUT;
                    r_id_idx    <= 2'd0;
                    spi_miso_oe <= 1'b1;
                  end
                  c_cmd_rdsr: begin
                    r_state     <= ST_STAT_OUT;
                    spi_miso_oe <= 1'b1;
                  end
                  c_cmd_read: begin
                    r_state   <= ST_ADDR;
                    r_is_prog <= 1'b0;
                  end
                  c_cmd_pp: begin
                    r_state   <= ST_ADDR;
                    r_is_prog <= 1'b1;
                  end
                  default: r_state <= ST_IGNORE;  // WREN/WRDI act at csn rise
                endcase
              end
              ST_ADDR: begin
                r_addr     <= w_addr_full;
                r_addr_cnt <= r_addr_cnt + 2'd1;
                if (r_addr_cnt == 2'd2) begin
                  if (r_is_prog) begin
                    r_state          <= ST_WR_DATA;
                    r_prog_addr_done <= 1'b1;
                  end else begin
                    r_state     <= ST_RD_DATA;
                    spi_miso_oe <= 1'b1;
                    mem_addr    <= w_addr_full;
                    mem_rd      <= 1'b1;
                  end
                end
              end
              ST_RD_DATA: begin
                // Prefetch the following byte; 24-bit address wraps naturally
                r_addr   <= r_addr + 24'd1;
                mem_addr <= r_addr + 24'd1;
                mem_rd   <= 1'b1;
              end
              ST_WR_DATA: begin
                if (wel) begin
                  mem_wr    <= 1'b1;
                  mem_wdata <= w_byte;
                  mem_addr  <= r_addr;
                  r_addr    <= {r_addr[23:8], r_addr[7:0] + 8'd1};
                end
              end
              default: ;
            endcase
          end
        end

        if (w_sck_fall && w_out_state) begin
          if (r_bit_cnt == 3'd0) begin
            // Byte boundary: present MSB of the next outgoing byte
            spi_miso <= w_next_byte[7];
            r_out_sr <= {w_next_byte[6:0], 1'b0};
            if (r_state == ST_ID_OUT)
              r_id_idx <= (r_id_idx == 2'd2) ? 2'd0 : r_id_idx + 2'd1;
          end else begin
            spi_miso <= r_out_sr[7];
            r_out_sr <= {r_out_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_slave
// Brief    : Self-checking bench for spi_flash_slave with an SPI master,
//            a byte-wide memory model and a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_flash_slave;

  localparam logic [23:0] c_id   = 24'hEF4018;
  localparam int          c_half = 8;   // clocks per sck half period

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic        wel;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_wel = 1'b0;

  logic [23:0] rd_log[$];
  logic [31:0] wr_log[$];

  spi_flash_slave #(.ID(c_id), .DIV_MIN(8)) dut (
    .clock(clock), .rst_n(rst_n), .spi_csn(spi_csn), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .wel(wel)
  );

  always #5 clock = ~clock;

  // Memory contents are a fixed function of the address
  function automatic logic [7:0] mem_val(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Synchronous read memory: data valid one clock after the strobe
  always @(posedge clock) if (mem_rd) mem_rdata <= mem_val(mem_addr);

  // Record every memory strobe away from the active edge
  always @(negedge clock) begin
    if (mem_rd) rd_log.push_back(mem_addr);
    if (mem_wr) wr_log.push_back({mem_addr, mem_wdata});
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic cs_begin;
    clk_wait(4);
    spi_csn = 1'b0;
    clk_wait(c_half);
  endtask

  task automatic cs_end;
    clk_wait(c_half);
    spi_csn = 1'b1;
    clk_wait(12);
  endtask

  // Mode-0 master: drive on falling side, sample miso as sck rises
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      clk_wait(c_half);
      spi_sck = 1'b1;
      rx[7-i] = spi_miso;
      clk_wait(c_half);
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  // One-byte frame, optionally followed by extra bits
  task automatic short_frame(input logic [7:0] op, input int extra);
    logic [7:0] rx;
    cs_begin();
    spi_byte(op, rx);
    if (extra > 0) spi_bits(8'($urandom), extra, rx);
    cs_end();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clk_wait(5);
    if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
    n_checks++;
    if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
    n_checks++;
    if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
    n_checks++;
    if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
    n_checks++;
    if (mem_addr !== 24'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 000000", mem_addr); end
    n_checks++;
    if (mem_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
    n_checks++;
    if (wel !== 1'b0) begin n_fail++; $display("FAIL reset_wel: got %b want 0", wel); end
    n_checks++;
    rst_n = 1'b1;
    clk_wait(10);
  endtask

  task automatic test_read_id;
    logic [7:0] rx, exp;
    int nb;
    nb = $urandom_range(3, 7);
    cs_begin();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < nb; i++) begin
      spi_byte(8'($urandom), rx);
      exp = 8'(c_id >> (8 * (2 - (i % 3))));
      if (rx !== exp) begin n_fail++; $display("FAIL rdid_byte%0d: got %h want %h", i, rx, exp); end
      n_checks++;
      if (spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL rdid_oe%0d: got %b want 1", i, spi_miso_oe); end
      n_checks++;
    end
    cs_end();
    if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL rdid_oe_end: got %b want 0", spi_miso_oe); end
    n_checks++;
  endtask

  task automatic check_status(input string tag);
    logic [7:0] rx, exp;
    int nb;
    nb = $urandom_range(1, 3);
    exp = {6'b0, model_wel, 1'b0};
    cs_begin();
    spi_byte(8'h05, rx);
    for (int i = 0; i < nb; i++) begin
      spi_byte(8'($urandom), rx);
      if (rx !== exp) begin n_fail++; $display("FAIL status_%s_%0d: got %h want %h", tag, i, rx, exp); end
      n_checks++;
    end
    cs_end();
  endtask

  task automatic test_wel_status;
    int kind, extra;
    short_frame(8'h06, 0);
    model_wel = 1'b1;
    check_status("wren");
    short_frame(8'h04, 0);
    model_wel = 1'b0;
    check_status("wrdi");
    // Random mix including frames that are not exactly 8 bits long
    for (int k = 0; k < 8; k++) begin
      kind  = $urandom_range(0, 1);
      extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 9) : 0;
      short_frame(kind == 1 ? 8'h06 : 8'h04, extra);
      if (extra == 0) model_wel = (kind == 1);
      if (wel !== model_wel) begin n_fail++; $display("FAIL wel_mix%0d: got %b want %b", k, wel, model_wel); end
      n_checks++;
    end
    check_status("mix");
  endtask

  task automatic program_frame(input logic [23:0] addr, input int n, input logic [7:0] data[8]);
    logic [7:0] rx;
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(addr[23:16], rx);
    spi_byte(addr[15:8], rx);
    spi_byte(addr[7:0], rx);
    for (int i = 0; i < n; i++) spi_byte(data[i], rx);
    cs_end();
    model_wel = 1'b0;   // completed address phase clears the latch
  endtask

  task automatic test_program;
    logic [7:0]  data[8];
    logic [23:0] addr, ea;
    logic [31:0] exp;
    int n;
    bit en;
    // Fixed page-wrap case
    short_frame(8'h06, 0);
    model_wel = 1'b1;
    wr_log.delete();
    data[0] = 8'hA1; data[1] = 8'hA2; data[2] = 8'hA3;
    program_frame(24'h0064FE, 3, data);
    if (wr_log.size() != 3) begin n_fail++; $display("FAIL pp_fixed_count: got %0d want 3", wr_log.size()); end
    else begin
      if (wr_log[0] !== 32'h0064FEA1) begin n_fail++; $display("FAIL pp_fixed_0: got %h want 0064FEA1", wr_log[0]); end
      n_checks++;
      if (wr_log[1] !== 32'h0064FFA2) begin n_fail++; $display("FAIL pp_fixed_1: got %h want 0064FFA2", wr_log[1]); end
      n_checks++;
      if (wr_log[2] !== 32'h006400A3) begin n_fail++; $display("FAIL pp_fixed_2: got %h want 006400A3", wr_log[2]); end
    end
    n_checks++;
    if (wel !== 1'b0) begin n_fail++; $display("FAIL pp_fixed_wel: got %b want 0", wel); end
    n_checks++;
    // Random programs; the first one is always without WREN
    for (int k = 0; k < 4; k++) begin
      en = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (en) begin short_frame(8'h06, 0); model_wel = 1'b1; end
      addr = 24'($urandom);
      if ($urandom_range(0, 1) == 1) addr[7:0] = 8'hFD;
      n = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) data[i] = 8'($urandom);
      wr_log.delete();
      program_frame(addr, n, data);
      if (wr_log.size() != (en ? n : 0)) begin
        n_fail++; $display("FAIL pp_rand%0d_count: got %0d want %0d", k, wr_log.size(), en ? n : 0);
      end else if (en) begin
        for (int i = 0; i < n; i++) begin
          ea  = {addr[23:8], 8'((addr[7:0] + i) % 256)};
          exp = {ea, data[i]};
          if (wr_log[i] !== exp) begin n_fail++; $display("FAIL pp_rand%0d_%0d: got %h want %h", k, i, wr_log[i], exp); end
          n_checks++;
        end
      end
      n_checks++;
      if (wel !== 1'b0) begin n_fail++; $display("FAIL pp_rand%0d_wel: got %b want 0", k, wel); end
      n_checks++;
    end
  endtask

  task automatic read_frame(input logic [23:0] addr, input int n, output logic [7:0] rx[8]);
    logic [7:0] d;
    cs_begin();
    spi_byte(8'h03, d);
    spi_byte(addr[23:16], d);
    spi_byte(addr[15:8], d);
    spi_byte(addr[7:0], d);
    for (int i = 0; i < n; i++) spi_byte(8'($urandom), rx[i]);
    cs_end();
  endtask

  task automatic test_read;
    logic [7:0]  rx[8];
    logic [23:0] addr, ea;
    int n;
    rd_log.delete();
    read_frame(24'hFFFFFF, 2, rx);
    if (rd_log.size() < 2) begin n_fail++; $display("FAIL rd_wrap_count: got %0d want >=2", rd_log.size()); end
    else begin
      if (rd_log[0] !== 24'hFFFFFF) begin n_fail++; $display("FAIL rd_wrap_addr0: got %h want FFFFFF", rd_log[0]); end
      n_checks++;
      if (rd_log[1] !== 24'h000000) begin n_fail++; $display("FAIL rd_wrap_addr1: got %h want 000000", rd_log[1]); end
    end
    n_checks++;
    if (rx[0] !== mem_val(24'hFFFFFF)) begin n_fail++; $display("FAIL rd_wrap_data0: got %h want %h", rx[0], mem_val(24'hFFFFFF)); end
    n_checks++;
    if (rx[1] !== mem_val(24'h000000)) begin n_fail++; $display("FAIL rd_wrap_data1: got %h want %h", rx[1], mem_val(24'h0)); end
    n_checks++;
    for (int k = 0; k < 3; k++) begin
      addr = 24'($urandom);
      n = $urandom_range(1, 5);
      read_frame(addr, n, rx);
      for (int i = 0; i < n; i++) begin
        ea = addr + 24'(i);
        if (rx[i] !== mem_val(ea)) begin n_fail++; $display("FAIL rd_rand%0d_%0d: got %h want %h", k, i, rx[i], mem_val(ea)); end
        n_checks++;
      end
    end
  endtask

  task automatic test_partial_write;
    logic [7:0] rx;
    short_frame(8'h06, 0);
    model_wel = 1'b1;
    wr_log.delete();
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h12, rx);
    spi_byte(8'h34, rx);
    spi_byte(8'h56, rx);
    spi_bits(8'($urandom), 5, rx);
    cs_end();
    model_wel = 1'b0;
    if (wr_log.size() != 0) begin n_fail++; $display("FAIL partial_wr_count: got %0d want 0", wr_log.size()); end
    n_checks++;
    if (wel !== 1'b0) begin n_fail++; $display("FAIL partial_wel: got %b want 0", wel); end
    n_checks++;
    if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL partial_oe: got %b want 0", spi_miso_oe); end
    n_checks++;
    check_status("after_partial");
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] rx;
    int nrd, nwr;
    cs_begin();
    spi_byte(8'h9F, rx);
    spi_byte(8'h00, rx);
    if (spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL midrst_oe_before: got %b want 1", spi_miso_oe); end
    n_checks++;
    rst_n = 1'b0;
    clk_wait(3);
    if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_oe: got %b want 0", spi_miso_oe); end
    n_checks++;
    if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL midrst_miso: got %b want 0", spi_miso); end
    n_checks++;
    if ({mem_rd, mem_wr, mem_addr, mem_wdata, wel} !== 35'h0) begin
      n_fail++; $display("FAIL midrst_mem: got rd=%b wr=%b addr=%h wdata=%h wel=%b want all 0",
                         mem_rd, mem_wr, mem_addr, mem_wdata, wel);
    end
    n_checks++;
    rst_n = 1'b1;
    model_wel = 1'b0;
    clk_wait(4);
    nrd = rd_log.size();
    nwr = wr_log.size();
    // Frame continues with csn still low: must be ignored entirely
    spi_byte(8'h9F, rx);
    spi_byte(8'h00, rx);
    if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_after_oe: got %b want 0", spi_miso_oe); end
    n_checks++;
    if (rx !== 8'h00) begin n_fail++; $display("FAIL midrst_after_miso: got %h want 00", rx); end
    n_checks++;
    if (rd_log.size() != nrd || wr_log.size() != nwr) begin
      n_fail++; $display("FAIL midrst_after_mem: got %0d/%0d strobes want 0", rd_log.size() - nrd, wr_log.size() - nwr);
    end
    n_checks++;
    cs_end();
    cs_begin();
    spi_byte(8'h9F, rx);
    spi_byte(8'h00, rx);
    cs_end();
    if (rx !== c_id[23:16]) begin n_fail++; $display("FAIL midrst_recover: got %h want %h", rx, c_id[23:16]); end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_wel_status();
    test_program();
    test_read();
    test_partial_write();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
